sp_mem_responder: RTL and testbench

Memory-side responder for the processor's req/ack memory interfaces. One instance serves instruction fetch and another serves data load/store. It accepts a request held by the initiator, waits a parameterised number of cycles, performs the read or write, and returns a one-cycle ack with registered read data. A backdoor write port lets benches and boot logic preload contents.

---
 rtl/simple_processor_pkg.sv | 14 +
 rtl/sp_mem_array.sv | 47 ++++
 rtl/sp_mem_responder.sv | 143 ++++++++++++++
 tb/tb_sp_mem_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/simple_processor_pkg.sv
// Shared widths, memory depth and the memory responder state encoding.
package simple_processor_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 16;
  localparam int MEM_DEPTH  = 256;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ACK  = 2'd2
  } mem_state_t;

endpackage

// File: rtl/sp_mem_array.sv
// Word storage with one synchronous read port and two write ports.
// When both write ports address the same word on one edge, the bus port wins.
module sp_mem_array
  import simple_processor_pkg::*;
#(
  parameter int MEM_DATA_WIDTH = DATA_WIDTH,
  parameter int DEPTH          = MEM_DEPTH,
  parameter int IDX_W          = $clog2(DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      bus_we_i,
  input  logic [IDX_W-1:0]          bus_idx_i,
  input  logic [MEM_DATA_WIDTH-1:0] bus_wdata_i,
  input  logic                      bd_we_i,
  input  logic [IDX_W-1:0]          bd_idx_i,
  input  logic [MEM_DATA_WIDTH-1:0] bd_wdata_i,
  input  logic                      rd_en_i,
  input  logic [IDX_W-1:0]          rd_idx_i,
  output logic [MEM_DATA_WIDTH-1:0] rdata_o
);

  logic [MEM_DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [MEM_DATA_WIDTH-1:0] r_rdata;
  logic                      w_bd_blocked;

  assign w_bd_blocked = bus_we_i && (bus_idx_i == bd_idx_i);

  // Write ports; the backdoor yields to a bus write on the same word.
  always_ff @(posedge clk_i) begin
    if (bd_we_i && !w_bd_blocked) begin
      r_mem[bd_idx_i] <= bd_wdata_i;
    end
    if (bus_we_i) begin
      r_mem[bus_idx_i] <= bus_wdata_i;
    end
  end

  // Registered read; a same-edge write to the word returns the old contents.
  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      r_rdata <= r_mem[rd_idx_i];
    end
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/sp_mem_responder.sv
// Memory-side responder for the req/ack bus: latches a request, waits
// WAIT_CYCLES, performs the access and pulses ack with registered data.
//
//   state    | meaning
//   MEM_IDLE | waiting for req_i; latches the request when it is seen
//   MEM_WAIT | counting down the configured wait cycles
//   MEM_ACK  | ack_o high for this single cycle; req_i ignored
module sp_mem_responder
  import simple_processor_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = ADDR_WIDTH,
  parameter int MEM_DATA_WIDTH = DATA_WIDTH,
  parameter int DEPTH          = MEM_DEPTH,
  parameter int WAIT_CYCLES    = 0
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [MEM_ADDR_WIDTH-1:0] addr_i,
  input  logic [MEM_DATA_WIDTH-1:0] wdata_i,
  output logic [MEM_DATA_WIDTH-1:0] rdata_o,
  output logic                      ack_o,
  output logic                      err_o,
  input  logic                      bd_we_i,
  input  logic [MEM_ADDR_WIDTH-1:0] bd_addr_i,
  input  logic [MEM_DATA_WIDTH-1:0] bd_wdata_i
);

  localparam int         BYTE_OFF = $clog2(MEM_DATA_WIDTH / 8);
  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LD  = 4'(WAIT_CYCLES);

  mem_state_t                r_state;
  logic [3:0]                r_cnt;
  logic                      r_we;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic [MEM_DATA_WIDTH-1:0] r_wdata;
  logic                      r_ack;
  logic                      r_err;
  logic                      r_rd_zero;

  logic                      w_t_we;
  logic [MEM_ADDR_WIDTH-1:0] w_t_addr;
  logic [MEM_DATA_WIDTH-1:0] w_t_wdata;
  logic [MEM_ADDR_WIDTH-1:0] w_t_word;
  logic                      w_t_in_range;
  logic [IDX_W-1:0]          w_t_idx;
  logic [MEM_ADDR_WIDTH-1:0] w_bd_word;
  logic                      w_bd_in_range;
  logic [IDX_W-1:0]          w_bd_idx;
  logic                      w_enter_ack;
  logic [MEM_DATA_WIDTH-1:0] w_arr_rdata;

  // With zero wait the access happens on the sampling edge, so the live
  // inputs stand in for the not-yet-latched copies.
  assign w_t_we    = (r_state == MEM_IDLE) ? we_i    : r_we;
  assign w_t_addr  = (r_state == MEM_IDLE) ? addr_i  : r_addr;
  assign w_t_wdata = (r_state == MEM_IDLE) ? wdata_i : r_wdata;

  // DEPTH is a power of two, so range means no bits above the index.
  assign w_t_word      = w_t_addr >> BYTE_OFF;
  assign w_t_in_range  = ((w_t_word >> IDX_W) == '0);
  assign w_t_idx       = w_t_word[IDX_W-1:0];
  assign w_bd_word     = bd_addr_i >> BYTE_OFF;
  assign w_bd_in_range = ((w_bd_word >> IDX_W) == '0);
  assign w_bd_idx      = w_bd_word[IDX_W-1:0];

  assign w_enter_ack = ((r_state == MEM_IDLE) && req_i && (WAIT_LD == 4'd0)) ||
                       ((r_state == MEM_WAIT) && (r_cnt == 4'd1));

  sp_mem_array #(
    .MEM_DATA_WIDTH(MEM_DATA_WIDTH),
    .DEPTH         (DEPTH),
    .IDX_W         (IDX_W)
  ) u_array (
    .clk_i      (clk_i),
    .bus_we_i   (w_enter_ack && w_t_we && w_t_in_range),
    .bus_idx_i  (w_t_idx),
    .bus_wdata_i(w_t_wdata),
    .bd_we_i    (bd_we_i && w_bd_in_range),
    .bd_idx_i   (w_bd_idx),
    .bd_wdata_i (bd_wdata_i),
    .rd_en_i    (w_enter_ack && !w_t_we && w_t_in_range),
    .rd_idx_i   (w_t_idx),
    .rdata_o    (w_arr_rdata)
  );

  // Request latching, wait counter and state sequencing.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state <= MEM_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        MEM_IDLE: begin
          if (req_i) begin
            r_we    <= we_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_cnt   <= WAIT_LD;
            r_state <= (WAIT_LD == 4'd0) ? MEM_ACK : MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= MEM_ACK;
          end
        end
        MEM_ACK: begin
          r_state <= MEM_IDLE;
        end
        default: begin
          r_state <= MEM_IDLE;
        end
      endcase
    end
  end

  // Ack/error pulse and read-data masking; the array holds the last good read.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_rd_zero <= 1'b1;
    end else begin
      r_ack <= w_enter_ack;
      r_err <= w_enter_ack && !w_t_in_range;
      if (w_enter_ack && !w_t_we) begin
        r_rd_zero <= !w_t_in_range;
      end
    end
  end

  assign ack_o   = r_ack;
  assign err_o   = r_err;
  assign rdata_o = r_rd_zero ? '0 : w_arr_rdata;

endmodule

// File: tb/tb_sp_mem_responder.sv
// Directed bench: three responders with WAIT_CYCLES of 2, 0 and 3.
module tb_sp_mem_responder;
  import simple_processor_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req      [3];
  logic        we       [3];
  logic [15:0] addr     [3];
  logic [15:0] wdata    [3];
  logic [15:0] rdata    [3];
  logic        ack      [3];
  logic        err      [3];
  logic        bd_we    [3];
  logic [15:0] bd_addr  [3];
  logic [15:0] bd_wdata [3];

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sp_mem_responder #(
      .MEM_ADDR_WIDTH(16),
      .MEM_DATA_WIDTH(16),
      .DEPTH         (256),
      .WAIT_CYCLES   ((g == 0) ? 2 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk_i     (clk),
      .arst_ni   (rst_n),
      .req_i     (req[g]),
      .we_i      (we[g]),
      .addr_i    (addr[g]),
      .wdata_i   (wdata[g]),
      .rdata_o   (rdata[g]),
      .ack_o     (ack[g]),
      .err_o     (err[g]),
      .bd_we_i   (bd_we[g]),
      .bd_addr_i (bd_addr[g]),
      .bd_wdata_i(bd_wdata[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input int i, input logic [15:0] a, input logic [15:0] d);
    bd_we[i] = 1'b1; bd_addr[i] = a; bd_wdata[i] = d;
    step();
    bd_we[i] = 1'b0;
  endtask

  // Issues one request from idle; lat counts edges after the sampling edge.
  task automatic bus_txn(input int i, input logic w, input logic [15:0] a, input logic [15:0] d,
                         output int lat, output logic [15:0] rd, output logic e);
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
    step();
    lat = 0;
    while (!ack[i] && lat < 40) begin
      step();
      lat++;
    end
    rd = rdata[i];
    e  = err[i];
    req[i] = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    int          seen;
    logic [15:0] rd;
    logic        e;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
      bd_we[i] = 1'b0; bd_addr[i] = '0; bd_wdata[i] = '0;
    end
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // 1: reset values and a backdoor-preloaded read with two wait cycles
    check("rst_ack", ack[0], 0);
    check("rst_rdata", rdata[0], 16'h0000);
    check("rst_err", err[0], 0);
    bd_write(0, 16'h0010, 16'h1234);
    bus_txn(0, 1'b0, 16'h0010, 16'h0000, lat, rd, e);
    check("t1_lat", lat, 2);
    check("t1_rdata", rd, 16'h1234);
    check("t1_err", e, 0);
    check("t1_ack_drop", ack[0], 0);
    check("t1_rdata_hold", rdata[0], 16'h1234);

    // 2: zero wait, req held high, ack every second cycle
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'h0020; wdata[1] = 16'hBEEF;
    step();
    check("t2_ack_w", ack[1], 1);
    check("t2_rd_on_w", rdata[1], 16'h0000);
    we[1] = 1'b0;
    step();
    check("t2_gap1", ack[1], 0);
    step();
    check("t2_ack_r", ack[1], 1);
    check("t2_rd_r", rdata[1], 16'hBEEF);
    we[1] = 1'b1; wdata[1] = 16'h1111;
    step();
    check("t2_gap2", ack[1], 0);
    step();
    check("t2_ack_w2", ack[1], 1);
    check("t2_rd_on_w2", rdata[1], 16'hBEEF);
    req[1] = 1'b0;
    step();

    // 3: misaligned read aligns down
    bus_txn(1, 1'b1, 16'h0020, 16'h5A5A, lat, rd, e);
    bus_txn(1, 1'b0, 16'h0021, 16'h0000, lat, rd, e);
    check("t3_lat", lat, 0);
    check("t3_rdata", rd, 16'h5A5A);

    // 4: out-of-range accesses on the two-wait instance
    bd_write(0, 16'h0000, 16'h0F0F);
    bus_txn(0, 1'b1, 16'h0200, 16'hDEAD, lat, rd, e);
    check("t4_lat", lat, 2);
    check("t4_err", e, 1);
    check("t4_err_clear", err[0], 0);
    bus_txn(0, 1'b0, 16'h0000, 16'h0000, lat, rd, e);
    check("t4_rd0", rd, 16'h0F0F);
    check("t4_rd0_err", e, 0);
    bd_write(0, 16'h0200, 16'hBAD0);
    check("t4_bd_noerr", err[0], 0);
    bus_txn(0, 1'b0, 16'h0000, 16'h0000, lat, rd, e);
    check("t4_bd_oor_ignored", rd, 16'h0F0F);
    bus_txn(0, 1'b0, 16'h0300, 16'h0000, lat, rd, e);
    check("t4_oor_rd_zero", rd, 16'h0000);
    check("t4_oor_rd_err", e, 1);

    // 5: req dropped and addr changed after sampling, three wait cycles
    bd_write(2, 16'h0050, 16'h5050);
    bd_write(2, 16'h0060, 16'h6060);
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 16'h0050;
    step();
    req[2] = 1'b0; addr[2] = 16'h0060;
    lat = 0;
    while (!ack[2] && lat < 40) begin
      step();
      lat++;
    end
    check("t5_lat", lat, 3);
    check("t5_rdata", rdata[2], 16'h5050);
    step();

    // 6: reset during the wait of a pending write
    bd_write(0, 16'h0030, 16'h3030);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0030; wdata[0] = 16'hCAFE;
    step();
    req[0] = 1'b0;
    step();
    check("t6_pre_ack", ack[0], 0);
    rst_n = 1'b0;
    seen = 0;
    repeat (3) begin
      step();
      if (ack[0]) seen++;
    end
    check("t6_no_ack", seen, 0);
    rst_n = 1'b1;
    step();
    bus_txn(0, 1'b0, 16'h0030, 16'h0000, lat, rd, e);
    check("t6_rd_prior", rd, 16'h3030);

    // 6b: simultaneous bus and backdoor writes to one word; bus wins
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'h0040; wdata[1] = 16'h4444;
    bd_we[1] = 1'b1; bd_addr[1] = 16'h0040; bd_wdata[1] = 16'h0B0B;
    step();
    bd_we[1] = 1'b0; req[1] = 1'b0;
    check("t6b_ack", ack[1], 1);
    step();
    bus_txn(1, 1'b0, 16'h0040, 16'h0000, lat, rd, e);
    check("t6b_bus_wins", rd, 16'h4444);

    // 6c: read completing with a same-word backdoor write returns old data
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0040;
    bd_we[1] = 1'b1; bd_addr[1] = 16'h0040; bd_wdata[1] = 16'h7777;
    step();
    bd_we[1] = 1'b0; req[1] = 1'b0;
    check("t6c_old_data", rdata[1], 16'h4444);
    step();
    bus_txn(1, 1'b0, 16'h0040, 16'h0000, lat, rd, e);
    check("t6c_new_data", rd, 16'h7777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
